// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU/register-file sequencer.
package alu_sched_pkg;

    // Width of the ALU control field carried in a request.
    localparam int unsigned ALU_CTRL_W = 1;

    // Width of the starvation counter; it covers the largest legal limit of 15.
    localparam int unsigned STARVE_CNT_W = 4;

    // Architectural zero register; writes to it are discarded.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One decoded operation as presented by a requester.
    typedef struct packed {
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [31:0]           imm;
        logic                  alusrc;
        logic [ALU_CTRL_W-1:0] aluctrl;
        logic                  wb_en;
    } alu_req_t;

    // Sequencer states: wait for a request, drive operands, write back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } sched_state_t;

    // A write-back only reaches the register file when enabled and not aimed at x0.
    function automatic logic writes_reg(input logic wb_en, input logic [4:0] rd);
        return wb_en && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/alu_rf_arb.sv
// Two-requester fixed-priority arbiter. Requester 0 wins ties until it has
// taken STARVE_LIM grants in a row while requester 1 waited; then requester 1
// is forced through once.
module alu_rf_arb
    import alu_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic gnt0,
    output logic gnt1,
    output logic update
);

    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    force1;

    // Grants are only issued while the sequencer can accept an operation.
    always_comb begin
        force1 = (starve_cnt == STARVE_CNT_W'(STARVE_LIM));
        gnt0   = enable && req0_valid && !(req1_valid && force1);
        gnt1   = enable && req1_valid && (!req0_valid || force1);
        update = gnt0 || gnt1;
    end

    // Count requester-0 wins over a waiting requester 1; clear once 1 is served or gone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (enable) begin
            if (gnt1 || !req1_valid) begin
                starve_cnt <= '0;
            end else if (gnt0 && !force1) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rf_sched.sv
// Multi-cycle sequencer in front of the ALU/register-file datapath.
// One operation takes three cycles: accept (IDLE), drive operands (EXEC) and
// write back with a completion pulse to its owner (WB).
module alu_rf_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned CTRL_W     = ALU_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  alu_req_t          req0_op,
    output logic              req0_done,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  alu_req_t          req1_op,
    output logic              req1_done,
    output logic              eq_out,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [31:0]       ImmOp,
    output logic              ALUsrc,
    output logic [CTRL_W-1:0] ALUcrtl,
    output logic              RegWrite,
    input  logic              EQ
);

    sched_state_t state;
    logic         gnt0;
    logic         gnt1;
    logic         handshake;
    logic         owner;
    logic         wb_en_q;
    logic         eq_q;
    alu_req_t     sel_op;

    alu_rf_arb #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state == IDLE),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .update     (handshake)
    );

    // A grant only exists for a valid requester, so ready doubles as the handshake.
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign eq_out     = eq_q;

    // Route the winning requester's operation into the sequencer.
    always_comb begin
        sel_op = gnt1 ? req1_op : req0_op;
    end

    // Sequencer: operand fields are captured on the handshake and held through WB,
    // so the ALU result stays stable up to the register-file write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            wb_en_q   <= 1'b0;
            eq_q      <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            ImmOp     <= '0;
            ALUsrc    <= 1'b0;
            ALUcrtl   <= '0;
            RegWrite  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state   <= EXEC;
                        owner   <= gnt1;
                        wb_en_q <= sel_op.wb_en;
                        rs1     <= sel_op.rs1;
                        rs2     <= sel_op.rs2;
                        rd      <= sel_op.rd;
                        ImmOp   <= sel_op.imm;
                        ALUsrc  <= sel_op.alusrc;
                        ALUcrtl <= CTRL_W'(sel_op.aluctrl);
                    end
                end
                EXEC: begin
                    state     <= WB;
                    eq_q      <= EQ;
                    RegWrite  <= writes_reg(wb_en_q, rd);
                    req0_done <= !owner;
                    req1_done <= owner;
                end
                WB: begin
                    state     <= IDLE;
                    owner     <= 1'b0;
                    wb_en_q   <= 1'b0;
                    eq_q      <= 1'b0;
                    rs1       <= '0;
                    rs2       <= '0;
                    rd        <= '0;
                    ImmOp     <= '0;
                    ALUsrc    <= 1'b0;
                    ALUcrtl   <= '0;
                    RegWrite  <= 1'b0;
                    req0_done <= 1'b0;
                    req1_done <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    RegWrite  <= 1'b0;
                    req0_done <= 1'b0;
                    req1_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rf_sched.sv
// Directed bench for alu_rf_sched with a completion scoreboard.
module tb_alu_rf_sched;
    import alu_sched_pkg::*;

    typedef struct packed {
        logic     owner;
        logic     eq;
        logic     rw;
        alu_req_t op;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req0_valid;
    logic              req0_ready;
    alu_req_t          req0_op;
    logic              req0_done;
    logic              req1_valid;
    logic              req1_ready;
    alu_req_t          req1_op;
    logic              req1_done;
    logic              eq_out;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       ImmOp;
    logic              ALUsrc;
    logic [ALU_CTRL_W-1:0] ALUcrtl;
    logic              RegWrite;
    logic              EQ;

    int   checks;
    int   errors;
    int   done0_cnt;
    int   done1_cnt;
    exp_t sb[$];
    exp_t mon_e;

    alu_rf_sched #(
        .STARVE_LIM (4),
        .CTRL_W     (ALU_CTRL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_done  (req1_done),
        .eq_out     (eq_out),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .ImmOp      (ImmOp),
        .ALUsrc     (ALUsrc),
        .ALUcrtl    (ALUcrtl),
        .RegWrite   (RegWrite),
        .EQ         (EQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic alu_req_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                    input logic [31:0] imm, input logic src,
                                    input logic [ALU_CTRL_W-1:0] ctl, input logic wb);
        alu_req_t r;
        r.rs1 = a; r.rs2 = b; r.rd = d; r.imm = imm;
        r.alusrc = src; r.aluctrl = ctl; r.wb_en = wb;
        return r;
    endfunction

    task automatic push(input logic who, input logic eqv, input alu_req_t op);
        exp_t e;
        e.owner = who;
        e.eq    = eqv;
        e.rw    = op.wb_en && (op.rd != 5'd0);
        e.op    = op;
        sb.push_back(e);
    endtask

    // Advance to the drive point just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every completion pulse must match the oldest expected op.
    always @(negedge clk) begin
        if (rst_n && (req0_done || req1_done)) begin
            if (req0_done) done0_cnt++;
            if (req1_done) done1_cnt++;
            chk1("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk1("sb_done0", req0_done, !mon_e.owner);
                chk1("sb_done1", req1_done, mon_e.owner);
                chk1("sb_eq", eq_out, mon_e.eq);
                chk1("sb_regwrite", RegWrite, mon_e.rw);
                chk32("sb_rs1", 32'(rs1), 32'(mon_e.op.rs1));
                chk32("sb_rs2", 32'(rs2), 32'(mon_e.op.rs2));
                chk32("sb_rd", 32'(rd), 32'(mon_e.op.rd));
                chk32("sb_imm", ImmOp, mon_e.op.imm);
                chk1("sb_alusrc", ALUsrc, mon_e.op.alusrc);
                chk1("sb_aluctrl", ALUcrtl[0], mon_e.op.aluctrl[0]);
            end
        end
        if (rst_n && RegWrite) begin
            chk1("regwrite_only_in_wb", req0_done || req1_done, 1'b1);
        end
    end

    // One isolated operation from a single requester, starting and ending in IDLE.
    task automatic single(input logic who, input alu_req_t op, input logic eqv, input string tag);
        if (who) begin req1_valid = 1'b1; req1_op = op; end
        else     begin req0_valid = 1'b1; req0_op = op; end
        EQ = eqv;
        push(who, eqv, op);
        @(negedge clk);
        chk1({tag, "_ready"}, who ? req1_ready : req0_ready, 1'b1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk32({tag, "_exec_rs1"}, 32'(rs1), 32'(op.rs1));
        chk32({tag, "_exec_rd"}, 32'(rd), 32'(op.rd));
        chk32({tag, "_exec_imm"}, ImmOp, op.imm);
        chk1({tag, "_exec_regwrite"}, RegWrite, 1'b0);
        cyc();
        @(negedge clk);
        chk1({tag, "_wb_done"}, who ? req1_done : req0_done, 1'b1);
        chk1({tag, "_wb_regwrite"}, RegWrite, op.wb_en && (op.rd != 5'd0));
        cyc();
    endtask

    // Both requesters held valid; seq[k] is the requester expected to win grant k.
    task automatic arb_run(input logic [9:0] seq, input int n, input string tag);
        alu_req_t o0;
        alu_req_t o1;
        o0 = mk(5'd10, 5'd11, 5'd12, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        o1 = mk(5'd20, 5'd21, 5'd13, 32'h0000_00AA, 1'b0, 1'b0, 1'b1);
        req0_op = o0;
        req1_op = o1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            EQ = k[0];
            push(seq[k], k[0], seq[k] ? o1 : o0);
            @(negedge clk);
            chk1($sformatf("%s_gnt0_%0d", tag, k), req0_ready, !seq[k]);
            chk1($sformatf("%s_gnt1_%0d", tag, k), req1_ready, seq[k]);
            cyc();
            cyc();
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        alu_req_t a;
        int       d0_before;
        int       d1_before;

        checks     = 0;
        errors     = 0;
        done0_cnt  = 0;
        done1_cnt  = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op    = '0;
        req1_op    = '0;
        EQ         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_regwrite", RegWrite, 1'b0);
        chk1("rst_done0", req0_done, 1'b0);
        chk1("rst_done1", req1_done, 1'b0);
        chk32("rst_rs1", 32'(rs1), 32'd0);
        chk32("rst_imm", ImmOp, 32'd0);
        chk1("rst_eq_out", eq_out, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("idle_ready0", req0_ready, 1'b0);
        chk1("idle_ready1", req1_ready, 1'b0);
        cyc();

        // Single op, valid held so the next acceptance lands three cycles later
        a = mk(5'd1, 5'd2, 5'd3, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
        req0_op = a;
        req0_valid = 1'b1;
        EQ = 1'b1;
        push(1'b0, 1'b1, a);
        @(negedge clk);
        chk1("t1_ready0_c0", req0_ready, 1'b1);
        chk1("t1_ready1_c0", req1_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk32("t1_rs1_c1", 32'(rs1), 32'd1);
        chk32("t1_rs2_c1", 32'(rs2), 32'd2);
        chk32("t1_rd_c1", 32'(rd), 32'd3);
        chk1("t1_regwrite_c1", RegWrite, 1'b0);
        chk1("t1_ready0_c1", req0_ready, 1'b0);
        chk1("t1_done_c1", req0_done, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t1_done_c2", req0_done, 1'b1);
        chk1("t1_ready0_c2", req0_ready, 1'b0);
        chk32("t1_rs1_c2", 32'(rs1), 32'd1);
        chk1("t1_regwrite_c2", RegWrite, 1'b1);
        cyc();
        EQ = 1'b0;
        push(1'b0, 1'b0, a);
        @(negedge clk);
        chk1("t1_ready0_c3", req0_ready, 1'b1);
        chk32("t1_rs1_c3", 32'(rs1), 32'd0);
        chk1("t1_regwrite_c3", RegWrite, 1'b0);
        cyc();
        req0_valid = 1'b0;
        cyc();
        cyc();

        // Suppressed writes: rd=x0, then write-back disabled; also one requester-1 op
        single(1'b0, mk(5'd4, 5'd5, 5'd0, 32'h0000_0001, 1'b0, 1'b1, 1'b1), 1'b1, "t2_rd0");
        single(1'b0, mk(5'd6, 5'd7, 5'd8, 32'h0000_0002, 1'b1, 1'b0, 1'b0), 1'b0, "t2_nowb");
        single(1'b1, mk(5'd9, 5'd3, 5'd14, 32'h8000_0000, 1'b1, 1'b1, 1'b1), 1'b1, "t2_req1");

        // Starvation limit with both requesters continuously valid
        d0_before = done0_cnt;
        d1_before = done1_cnt;
        arb_run(10'b10_0001_0000, 10, "t3");
        chk32("t3_done1_count", 32'(done1_cnt - d1_before), 32'd2);
        chk32("t3_done0_count", 32'(done0_cnt - d0_before), 32'd8);

        // Requester 1 withdraws while requester 0 is in flight
        d1_before = done1_cnt;
        a = mk(5'd2, 5'd4, 5'd6, 32'h0000_0040, 1'b0, 1'b0, 1'b1);
        req0_op = a;
        req1_op = mk(5'd7, 5'd7, 5'd7, 32'h0000_0077, 1'b1, 1'b1, 1'b1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        EQ = 1'b1;
        push(1'b0, 1'b1, a);
        @(negedge clk);
        chk1("t4_ready0", req0_ready, 1'b1);
        chk1("t4_ready1", req1_ready, 1'b0);
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        chk1("t4_ready1_exec", req1_ready, 1'b0);
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        chk1("t4_ready1_wb", req1_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t4_ready1_idle", req1_ready, 1'b0);
        cyc();
        chk32("t4_done1_count", 32'(done1_cnt - d1_before), 32'd0);
        // A cleared counter lets requester 0 take four grants again
        arb_run(10'b00_0001_0000, 5, "t4_recover");

        // Reset during WB aborts the write and the completion
        d0_before = done0_cnt;
        req0_op = mk(5'd1, 5'd1, 5'd5, 32'h0000_0005, 1'b0, 1'b0, 1'b1);
        req0_valid = 1'b1;
        EQ = 1'b1;
        cyc();
        req0_valid = 1'b0;
        cyc();
        #1;
        chk1("t5_regwrite_wb", RegWrite, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t5_regwrite_rst", RegWrite, 1'b0);
        chk1("t5_done_rst", req0_done, 1'b0);
        chk32("t5_rd_rst", 32'(rd), 32'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("t5_ready0_after", req0_ready, 1'b0);
        cyc();
        chk32("t5_done0_count", 32'(done0_cnt - d0_before), 32'd0);
        single(1'b0, mk(5'd3, 5'd4, 5'd5, 32'h0000_0055, 1'b0, 1'b1, 1'b1), 1'b0, "t5_after");

        // Back-to-back requester-0 ops with an all-ones immediate
        a = mk(5'd11, 5'd12, 5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        req0_op = a;
        req0_valid = 1'b1;
        EQ = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if ((c % 3) == 0) push(1'b0, 1'b1, a);
            @(negedge clk);
            chk1($sformatf("t6_ready0_%0d", c), req0_ready, (c % 3) == 0);
            chk32($sformatf("t6_imm_%0d", c), ImmOp, ((c % 3) == 0) ? 32'd0 : 32'hFFFF_FFFF);
            chk1($sformatf("t6_alusrc_%0d", c), ALUsrc, (c % 3) != 0);
            cyc();
        end
        req0_valid = 1'b0;
        cyc();
        cyc();

        chk32("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rf_sched.md
Name: alu_rf_sched

Overview:
- Multi-cycle sequencer and two-requester arbiter in front of the ALU/register-file datapath.
- Requester 0 is the core decode stage. Requester 1 is the debug/test loader port.
- The block accepts one decoded operation per handshake and drives the datapath controls (rs1, rs2, rd, ImmOp, ALUsrc, ALUcrtl, RegWrite) through EXEC and WB. It returns the EQ result with a done pulse to the granted requester.
- Fixed priority to requester 0, with a starvation limit that guarantees requester 1 progress.

Parameters:
- STARVE_LIM, 4: consecutive requester-0 grants allowed while requester 1 is pending before requester 1 is forced. Legal range 1..15.
- CTRL_W, 1: width of the ALU control field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 handshake accepted this cycle
- req0_op  in  alu_req_t  requester 0 operation
- req0_done  out  1  one-cycle completion pulse for requester 0
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 handshake accepted this cycle
- req1_op  in  alu_req_t  requester 1 operation
- req1_done  out  1  one-cycle completion pulse for requester 1
- eq_out  out  1  EQ result of the completed operation; valid while either done is high
- rs1  out  5  datapath source register 1
- rs2  out  5  datapath source register 2
- rd  out  5  datapath destination register
- ImmOp  out  32  datapath immediate
- ALUsrc  out  1  datapath operand-2 select
- ALUcrtl  out  CTRL_W  datapath ALU control
- RegWrite  out  1  datapath register write enable
- EQ  in  1  datapath equality flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, all datapath outputs 0, RegWrite 0, both ready 0, both done 0, eq_out 0, starvation counter 0.
- Assertion of rst_n mid-operation aborts the operation: no RegWrite is issued and no done pulse is produced.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - Arbitrate among valid requesters. Only the winner's ready is high, combinationally, in IDLE. A handshake is valid & ready.
  - On a handshake, latch the operation and owner id; next state is EXEC.
  - With no valid requester, remain in IDLE.
- EXEC (1 cycle):
  - Drive rs1, rs2, rd, ImmOp, ALUsrc and ALUcrtl from the latched operation. RegWrite=0.
  - Register EQ into eq_q at the end of the cycle. Next state is WB.
- WB (1 cycle):
  - Hold every datapath field unchanged, so ALUout stays stable up to the write edge.
  - RegWrite=1 iff wb_en=1 and rd!=0. A write to x0 is suppressed at this block.
  - Owner's done=1 and eq_out=eq_q. Next state is IDLE.
- Outside EXEC and WB, all datapath outputs are driven to 0.
- Latency: handshake in cycle N, EXEC in N+1, WB and done in N+2. Earliest next handshake is N+3. Throughput is 1 op per 3 cycles.
- Arbitration, when both requesters are valid:
  - Grant requester 0 unless starve_cnt==STARVE_LIM; in that case grant requester 1.
  - starve_cnt increments on each requester-0 grant while req1_valid=1.
  - starve_cnt clears on a requester-1 grant, or in any IDLE cycle with req1_valid=0.
  - starve_cnt saturates at STARVE_LIM.
- Requester rules:
  - A requester must hold valid and op stable until ready.
  - Dropping valid before ready is legal and withdraws the request with no side effects.
- Done pulses: never asserted outside WB. req0_done and req1_done are mutually exclusive.
- Ready in non-IDLE states: ready is 0 in EXEC and WB regardless of valid.

Decomposition:
- Package alu_sched_pkg holds:
  - typedef alu_req_t, a packed struct of rs1[4:0], rs2[4:0], rd[4:0], imm[31:0], alusrc, aluctrl[CTRL_W-1:0], wb_en;
  - the state enum {IDLE, EXEC, WB};
  - the localparam REG_ZERO=5'd0.
- One sub-module, alu_rf_arb, holds the fixed-priority arbiter with the starvation counter. Its outputs are gnt0, gnt1 and an update strobe.
- The FSM and datapath drive stay in the top module.

Test Plan:
- Single op: req0 {rs1=1, rs2=2, rd=3, alusrc=0, wb_en=1} -> ready in cycle 0; rs fields driven in cycles 1–2; RegWrite=1 only in cycle 2; req0_done=1 in cycle 2 with eq_out matching the preset EQ; next ready in cycle 3.
- rd=0 with wb_en=1, and a separate op with wb_en=0 -> RegWrite stays 0 through both ops; done still pulses at N+2.
- Both requesters valid continuously, STARVE_LIM=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; the req1_done count matches.
- req1 withdraws valid before ready, while req0 is busy -> no req1 grant, no req1_done, starve_cnt returns to 0.
- rst_n asserted low during WB with wb_en=1, rd=5 -> RegWrite drops to 0 immediately; no done; state is IDLE after release; a subsequent op completes normally.
- Back-to-back req0 ops with imm=32'hFFFF_FFFF and alusrc=1 -> ImmOp=32'hFFFF_FFFF and ALUsrc=1 are held stable across EXEC and WB; ops are spaced exactly 3 cycles apart.
